trap_ctrl: RTL and testbench

- Sits directly downstream of the pipeline trap stage; consumes its registered TRAP_EN/TRAP_PC/TRAP_CODE/TRAP_JMP_TO.
- Commits the trap: updates mepc/mcause/mstatus, pulses pipeline FLUSH and a fetch redirect, then holds off new traps while the pipeline drains.
- Also executes MRET, returning to mepc and restoring MIE.
- Generates INT_ALLOW, which feeds back to the trap stage.

---
 rtl/trap_ctrl_pkg.sv | 30 +++
 rtl/trap_csr_regs.sv | 69 ++++++
 rtl/trap_ctrl.sv | 111 +++++++++++
 tb/tb_trap_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared CSR definitions for the trap controller: CSR addresses, mstatus bit
// positions and FSM state encodings.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

    // MPP is hard-wired to machine mode; only MIE and MPIE are stored.
    function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie);
        logic [31:0] v;
        v = 32'h0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        v[MSTATUS_MIE]  = mie;
        v[MSTATUS_MPIE] = mpie;
        return v;
    endfunction

endpackage

// File: rtl/trap_csr_regs.sv
// Machine trap CSRs (mepc/mcause/mstatus). Trap commit beats MRET, and both
// beat a software CSR write in the same cycle.
module trap_csr_regs
    import trap_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_take_i,
    input  logic        mret_take_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_code_i,
    input  logic        csr_w_en_i,
    input  logic [11:0] csr_w_addr_i,
    input  logic [31:0] csr_w_data_i,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mstatus_o
);

    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;

    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        if (trap_take_i) begin
            mepc_d   = trap_pc_i & ~32'h3;
            mcause_d = trap_code_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_take_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_w_en_i) begin
            case (csr_w_addr_i)
                CSR_MSTATUS: begin
                    mie_d  = csr_w_data_i[MSTATUS_MIE];
                    mpie_d = csr_w_data_i[MSTATUS_MPIE];
                end
                CSR_MEPC:   mepc_d   = csr_w_data_i & ~32'h3;
                CSR_MCAUSE: mcause_d = csr_w_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

    assign mepc_o    = mepc_q;
    assign mcause_o  = mcause_q;
    assign mstatus_o = pack_mstatus(mie_q, mpie_q);

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET commit controller: redirects fetch, flushes the pipeline and then
// ignores further traps until DRAIN_CYCLES unstalled cycles have elapsed.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_JMP_TO,
    input  logic        MRET_EN,
    input  logic        CSR_W_EN,
    input  logic [11:0] CSR_W_ADDR,
    input  logic [31:0] CSR_W_DATA,
    output logic        FLUSH,
    output logic        JMP_DO,
    output logic [31:0] JMP_PC,
    output logic [31:0] MEPC,
    output logic [31:0] MCAUSE,
    output logic [31:0] MSTATUS,
    output logic        INT_ALLOW,
    output logic        BUSY
);

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] jmp_pc_q, jmp_pc_d;
    logic        trap_take, mret_take;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        jmp_pc_d  = jmp_pc_q;
        trap_take = 1'b0;
        mret_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!MEM_WAIT) begin
                    if (TRAP_EN) begin
                        trap_take = 1'b1;
                        jmp_pc_d  = TRAP_JMP_TO;
                        state_d   = ST_REDIRECT;
                    end else if (MRET_EN) begin
                        mret_take = 1'b1;
                        jmp_pc_d  = MEPC;
                        state_d   = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                state_d = ST_DRAIN;
                cnt_d   = DRAIN_INIT;
            end
            ST_DRAIN: begin
                // The last unstalled drain cycle hands straight back to IDLE.
                if (!MEM_WAIT) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            jmp_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            jmp_pc_q <= jmp_pc_d;
        end
    end

    trap_csr_regs u_csr (
        .clk_i        (CLK),
        .rst_i        (RST),
        .trap_take_i  (trap_take),
        .mret_take_i  (mret_take),
        .trap_pc_i    (TRAP_PC),
        .trap_code_i  (TRAP_CODE),
        .csr_w_en_i   (CSR_W_EN),
        .csr_w_addr_i (CSR_W_ADDR),
        .csr_w_data_i (CSR_W_DATA),
        .mepc_o       (MEPC),
        .mcause_o     (MCAUSE),
        .mstatus_o    (MSTATUS)
    );

    assign FLUSH     = (state_q == ST_REDIRECT);
    assign JMP_DO    = (state_q == ST_REDIRECT);
    assign JMP_PC    = jmp_pc_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign INT_ALLOW = MSTATUS[MSTATUS_MIE] && (state_q == ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a per-cycle vector table plus reset-recovery sequences.
module tb_trap_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_WAIT, TRAP_EN, MRET_EN, CSR_W_EN;
    logic [31:0] TRAP_PC, TRAP_CODE, TRAP_JMP_TO, CSR_W_DATA;
    logic [11:0] CSR_W_ADDR;
    logic        FLUSH, JMP_DO, INT_ALLOW, BUSY;
    logic [31:0] JMP_PC, MEPC, MCAUSE, MSTATUS;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    trap_ctrl #(.DRAIN_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .TRAP_EN(TRAP_EN),
        .TRAP_PC(TRAP_PC), .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO),
        .MRET_EN(MRET_EN), .CSR_W_EN(CSR_W_EN), .CSR_W_ADDR(CSR_W_ADDR),
        .CSR_W_DATA(CSR_W_DATA), .FLUSH(FLUSH), .JMP_DO(JMP_DO), .JMP_PC(JMP_PC),
        .MEPC(MEPC), .MCAUSE(MCAUSE), .MSTATUS(MSTATUS), .INT_ALLOW(INT_ALLOW),
        .BUSY(BUSY)
    );

    typedef struct {
        logic        mw;
        logic        te;
        logic [31:0] tpc;
        logic [31:0] tcode;
        logic [31:0] tjmp;
        logic        mr;
        logic        cw;
        logic [11:0] caddr;
        logic [31:0] cdata;
        logic        e_flush;
        logic        e_jdo;
        logic [31:0] e_jpc;
        logic [31:0] e_mepc;
        logic [31:0] e_mcause;
        logic [31:0] e_mstatus;
        logic        e_ia;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic fl, input logic jd,
                            input logic [31:0] jpc, input logic [31:0] mepc,
                            input logic [31:0] mcause, input logic [31:0] mst,
                            input logic ia, input logic busy);
        chk({tag, ".flush"},     {31'h0, FLUSH},     {31'h0, fl});
        chk({tag, ".jmp_do"},    {31'h0, JMP_DO},    {31'h0, jd});
        chk({tag, ".jmp_pc"},    JMP_PC,             jpc);
        chk({tag, ".mepc"},      MEPC,               mepc);
        chk({tag, ".mcause"},    MCAUSE,             mcause);
        chk({tag, ".mstatus"},   MSTATUS,            mst);
        chk({tag, ".int_allow"}, {31'h0, INT_ALLOW}, {31'h0, ia});
        chk({tag, ".busy"},      {31'h0, BUSY},      {31'h0, busy});
    endtask

    task automatic idle_inputs();
        MEM_WAIT = 0; TRAP_EN = 0; MRET_EN = 0; CSR_W_EN = 0;
        TRAP_PC = 0; TRAP_CODE = 0; TRAP_JMP_TO = 0;
        CSR_W_ADDR = 0; CSR_W_DATA = 0;
    endtask

    task automatic drive_trap(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] jt);
        @(negedge CLK);
        idle_inputs();
        TRAP_EN = 1; TRAP_PC = pc; TRAP_CODE = code; TRAP_JMP_TO = jt;
        @(posedge CLK); #1;
    endtask

    task automatic step_idle(input logic rst);
        @(negedge CLK);
        idle_inputs();
        RST = rst;
        @(posedge CLK); #1;
    endtask

    initial begin
        idle_inputs();
        RST = 1;

        //             mw te tpc           tcode         tjmp          mr cw caddr    cdata          fl jd jpc           mepc          mcause        mstatus       ia busy
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h300, 32'h8,         0, 0, 32'h0,    32'h0,        32'h0,        32'h1808, 1, 0}); // r0 set MIE
        vecs.push_back(vec_t'{0, 1, 32'h1006,     32'h2,        32'h8000,     0, 0, 12'h0,   32'h0,         1, 1, 32'h8000, 32'h1004,     32'h2,        32'h1880, 0, 1}); // r1 exception
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'h8000, 32'h1004,     32'h2,        32'h1880, 0, 1});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'h8000, 32'h1004,     32'h2,        32'h1880, 0, 1});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'h8000, 32'h1004,     32'h2,        32'h1880, 0, 0}); // r4 idle
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 12'h0,   32'h0,         1, 1, 32'h1004, 32'h1004,     32'h2,        32'h1888, 0, 1}); // r5 mret
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'h1004, 32'h1004,     32'h2,        32'h1888, 0, 1});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'h1004, 32'h1004,     32'h2,        32'h1888, 0, 1});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'h1004, 32'h1004,     32'h2,        32'h1888, 1, 0}); // r8 idle, ints on
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h300, 32'h0,         0, 0, 32'h1004, 32'h1004,     32'h2,        32'h1800, 0, 0});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h300, 32'hFFFF_FFFF, 0, 0, 32'h1004, 32'h1004,     32'h2,        32'h1888, 1, 0}); // r10
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h341, 32'h3,         0, 0, 32'h1004, 32'h0,        32'h2,        32'h1888, 1, 0});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h342, 32'h8000_000B, 0, 0, 32'h1004, 32'h0,        32'h8000_000B, 32'h1888, 1, 0});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h123, 32'h55,        0, 0, 32'h1004, 32'h0,        32'h8000_000B, 32'h1888, 1, 0}); // r13 bad addr
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h341, 32'h1234_5677, 0, 0, 32'h1004, 32'h1234_5674, 32'h8000_000B, 32'h1888, 1, 0});
        vecs.push_back(vec_t'{1, 1, 32'h2000,     32'h7,        32'h9000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h1004, 32'h1234_5674, 32'h8000_000B, 32'h1888, 1, 0}); // r15 stalled
        vecs.push_back(vec_t'{1, 1, 32'h2000,     32'h7,        32'h9000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h1004, 32'h1234_5674, 32'h8000_000B, 32'h1888, 1, 0});
        vecs.push_back(vec_t'{1, 1, 32'h2000,     32'h7,        32'h9000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h1004, 32'h1234_5674, 32'h8000_000B, 32'h1888, 1, 0});
        vecs.push_back(vec_t'{0, 1, 32'h2000,     32'h7,        32'h9000,     0, 0, 12'h0,   32'h0,         1, 1, 32'h9000, 32'h2000,     32'h7,        32'h1880, 0, 1}); // r18 accepted
        vecs.push_back(vec_t'{1, 1, 32'h2000,     32'h7,        32'h9000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h9000, 32'h2000,     32'h7,        32'h1880, 0, 1});
        vecs.push_back(vec_t'{1, 1, 32'h3000,     32'h9,        32'hB000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h9000, 32'h2000,     32'h7,        32'h1880, 0, 1}); // r20 drain stalled
        vecs.push_back(vec_t'{1, 1, 32'h3000,     32'h9,        32'hB000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h9000, 32'h2000,     32'h7,        32'h1880, 0, 1});
        vecs.push_back(vec_t'{0, 1, 32'h3000,     32'h9,        32'hB000,     0, 0, 12'h0,   32'h0,         0, 0, 32'h9000, 32'h2000,     32'h7,        32'h1880, 0, 1}); // r22 trap ignored
        vecs.push_back(vec_t'{0, 1, 32'h3000,     32'h9,        32'hB000,     0, 1, 12'h300, 32'h8,         0, 0, 32'h9000, 32'h2000,     32'h7,        32'h1808, 1, 0}); // r23 csr in drain
        vecs.push_back(vec_t'{0, 1, 32'h4003,     32'hB,        32'hA000,     1, 1, 12'h341, 32'hDEAD_BEEF, 1, 1, 32'hA000, 32'h4000,     32'hB,        32'h1880, 0, 1}); // r24 collision
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 12'h342, 32'h11,        0, 0, 32'hA000, 32'h4000,     32'h11,       32'h1880, 0, 1});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'hA000, 32'h4000,     32'h11,       32'h1880, 0, 1});
        vecs.push_back(vec_t'{0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 12'h0,   32'h0,         0, 0, 32'hA000, 32'h4000,     32'h11,       32'h1880, 0, 0});

        repeat (2) @(posedge CLK);
        #1;
        chk_outs("reset", 0, 0, 32'h0, 32'h0, 32'h0, 32'h1800, 0, 0);

        @(negedge CLK);
        RST = 0;
        foreach (vecs[i]) begin
            if (i != 0) @(negedge CLK);
            MEM_WAIT = vecs[i].mw;  TRAP_EN = vecs[i].te;
            TRAP_PC = vecs[i].tpc;  TRAP_CODE = vecs[i].tcode;
            TRAP_JMP_TO = vecs[i].tjmp; MRET_EN = vecs[i].mr;
            CSR_W_EN = vecs[i].cw;  CSR_W_ADDR = vecs[i].caddr;
            CSR_W_DATA = vecs[i].cdata;
            @(posedge CLK); #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_flush, vecs[i].e_jdo,
                     vecs[i].e_jpc, vecs[i].e_mepc, vecs[i].e_mcause,
                     vecs[i].e_mstatus, vecs[i].e_ia, vecs[i].e_busy);
        end

        // Reset while in REDIRECT.
        drive_trap(32'h5000, 32'h3, 32'hC000);
        chk_outs("pre_rst_redirect", 1, 1, 32'hC000, 32'h5000, 32'h3, 32'h1800, 0, 1);
        step_idle(1);
        chk_outs("rst_in_redirect", 0, 0, 32'h0, 32'h0, 32'h0, 32'h1800, 0, 0);
        @(negedge CLK);
        RST = 0;
        TRAP_EN = 1; TRAP_PC = 32'h6004; TRAP_CODE = 32'h4; TRAP_JMP_TO = 32'hD000;
        @(posedge CLK); #1;
        chk_outs("trap_after_rst1", 1, 1, 32'hD000, 32'h6004, 32'h4, 32'h1800, 0, 1);

        // Reset while in DRAIN.
        step_idle(0);
        chk_outs("in_drain", 0, 0, 32'hD000, 32'h6004, 32'h4, 32'h1800, 0, 1);
        step_idle(1);
        chk_outs("rst_in_drain", 0, 0, 32'h0, 32'h0, 32'h0, 32'h1800, 0, 0);
        @(negedge CLK);
        RST = 0;
        TRAP_EN = 1; TRAP_PC = 32'h7008; TRAP_CODE = 32'h5; TRAP_JMP_TO = 32'hE000;
        @(posedge CLK); #1;
        chk_outs("trap_after_rst2", 1, 1, 32'hE000, 32'h7008, 32'h5, 32'h1800, 0, 1);

        step_idle(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
